tx_arbiter_module: RTL and testbench

TX_ARBITER_MODULE -- requirements
Module: tx_arbiter_module

---
 rtl/tx_arbiter_module_pkg.sv | 10 +
 rtl/tx_arbiter_module.sv | 102 ++++++++++
 tb/tb_tx_arbiter_module.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_arbiter_module_pkg.sv
// Shared UART TX constants: default burst and idle-release limits for the
// two-channel TX arbiter that feeds tx_interface.
package tx_arbiter_module_pkg;

   // Bytes a channel may write per grant before it must re-arbitrate.
   localparam int unsigned TXARB_MAX_BURST_DEF    = 16;
   // Granted-but-idle cycles tolerated before the grant is withdrawn.
   localparam int unsigned TXARB_IDLE_TIMEOUT_DEF = 255;

endpackage : tx_arbiter_module_pkg

// File: rtl/tx_arbiter_module.sv
// Two-channel round-robin byte arbiter in front of the UART TX FIFO.
// One channel owns the FIFO write port per grant; a grant ends on a Last
// byte, after MAX_BURST bytes, or after IDLE_TIMEOUT idle cycles. A stall
// (FIFO full while the owner requests) never ends a grant.
module tx_arbiter_module
   import tx_arbiter_module_pkg::*;
#(
   parameter int unsigned MAX_BURST    = TXARB_MAX_BURST_DEF,
   parameter int unsigned IDLE_TIMEOUT = TXARB_IDLE_TIMEOUT_DEF
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Req0_Sig,
   input  logic [7:0] Data0,
   input  logic       Last0_Sig,
   output logic       Ack0_Sig,
   input  logic       Req1_Sig,
   input  logic [7:0] Data1,
   input  logic       Last1_Sig,
   output logic       Ack1_Sig,
   input  logic       Full_Sig,
   output logic       Write_Req_Sig,
   output logic [7:0] FIFO_Write_Data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   // Counter values seen during the cycle that triggers release.
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
   localparam logic [7:0] IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);

   state_e     state_q;
   logic [7:0] burst_q;
   logic [7:0] idle_q;
   logic       last_grant_q;

   logic       granted;
   logic       sel_req;
   logic       sel_last;
   logic [7:0] sel_data;
   logic       xfer;
   logic       pick1;

   // Mux the owning channel's request onto a common path; reset gates the
   // transfer so outputs are 0 the instant RSTn falls.
   always_comb begin
      granted  = (state_q == GRANT0) || (state_q == GRANT1);
      sel_req  = (state_q == GRANT1) ? Req1_Sig  : Req0_Sig;
      sel_last = (state_q == GRANT1) ? Last1_Sig : Last0_Sig;
      sel_data = (state_q == GRANT1) ? Data1     : Data0;
      xfer     = RSTn && granted && sel_req && !Full_Sig;
      // Channel 1 wins when alone, or on contention if channel 0 went last.
      pick1    = Req1_Sig && (!Req0_Sig || !last_grant_q);
   end

   // Write strobe, data and acks are combinational from the transfer term.
   always_comb begin
      Write_Req_Sig   = xfer;
      FIFO_Write_Data = xfer ? sel_data : 8'h00;
      Ack0_Sig        = xfer && (state_q == GRANT0);
      Ack1_Sig        = xfer && (state_q == GRANT1);
   end

   // Grant FSM with burst/idle counters and round-robin history.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= IDLE;
         burst_q      <= 8'h00;
         idle_q       <= 8'h00;
         last_grant_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (Req0_Sig || Req1_Sig) begin
                  state_q      <= pick1 ? GRANT1 : GRANT0;
                  last_grant_q <= pick1;
                  burst_q      <= 8'h00;
                  idle_q       <= 8'h00;
               end
            end
            GRANT0, GRANT1: begin
               if (xfer) begin
                  burst_q <= burst_q + 8'd1;
                  idle_q  <= 8'h00;
                  // Last and burst limit together still release only once.
                  if (sel_last || (burst_q == BURST_LAST)) state_q <= IDLE;
               end else if (!sel_req) begin
                  idle_q <= idle_q + 8'd1;
                  if (idle_q == IDLE_LAST) state_q <= IDLE;
               end
               // Stall: counters and grant hold.
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule : tx_arbiter_module

// File: tb/tb_tx_arbiter_module.sv
// Bench for tx_arbiter_module: channel byte queues drive the requests, a
// transaction-level ownership model predicts the outputs every cycle, and a
// write log is checked against hand-computed scenario results.
module tb_tx_arbiter_module;

   localparam int MAXB = 16;
   localparam int TO   = 255;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       Req0_Sig = 1'b0, Last0_Sig = 1'b0, Ack0_Sig;
   logic       Req1_Sig = 1'b0, Last1_Sig = 1'b0, Ack1_Sig;
   logic [7:0] Data0 = 8'h00, Data1 = 8'h00;
   logic       Full_Sig = 1'b0;
   logic       Write_Req_Sig;
   logic [7:0] FIFO_Write_Data;

   tx_arbiter_module #(.MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .Req0_Sig(Req0_Sig), .Data0(Data0), .Last0_Sig(Last0_Sig), .Ack0_Sig(Ack0_Sig),
      .Req1_Sig(Req1_Sig), .Data1(Data1), .Last1_Sig(Last1_Sig), .Ack1_Sig(Ack1_Sig),
      .Full_Sig(Full_Sig), .Write_Req_Sig(Write_Req_Sig), .FIFO_Write_Data(FIFO_Write_Data)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Pending bytes per channel as {last, data}.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   bit en0 = 1'b1, en1 = 1'b1;

   // Log of bytes the DUT actually wrote: channel, data, cycle.
   int         logc[$];
   logic [7:0] logd[$];
   int         logt[$];

   // Model: owner is -1 when nobody holds the FIFO.
   int m_own = -1;
   int m_bc = 0;
   int m_ic = 0;
   int m_lg = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int pick(input bit r0, input bit r1, input int lg);
      if (r0 && r1) return (lg == 1) ? 0 : 1;
      return r0 ? 0 : 1;
   endfunction

   // Ownership model advanced on each edge from the arbitration rules.
   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         m_own <= -1; m_bc <= 0; m_ic <= 0; m_lg <= 1;
      end else if (m_own < 0) begin
         if (Req0_Sig || Req1_Sig) begin
            m_own <= pick(Req0_Sig, Req1_Sig, m_lg);
            m_lg  <= pick(Req0_Sig, Req1_Sig, m_lg);
            m_bc  <= 0;
            m_ic  <= 0;
         end
      end else if ((m_own == 0 ? Req0_Sig : Req1_Sig) && !Full_Sig) begin
         m_bc <= m_bc + 1;
         m_ic <= 0;
         if ((m_own == 0 ? Last0_Sig : Last1_Sig) || (m_bc + 1 == MAXB)) m_own <= -1;
      end else if (!(m_own == 0 ? Req0_Sig : Req1_Sig)) begin
         m_ic <= m_ic + 1;
         if (m_ic + 1 == TO) m_own <= -1;
      end
   end

   task automatic compare_cycle();
      bit xf;
      logic [7:0] ed;
      xf = RSTn && (m_own >= 0) && (m_own == 0 ? Req0_Sig : Req1_Sig) && !Full_Sig;
      ed = xf ? (m_own == 0 ? Data0 : Data1) : 8'h00;
      chk("cycle_outputs",
          {21'd0, Write_Req_Sig, Ack0_Sig, Ack1_Sig, FIFO_Write_Data},
          {21'd0, xf, xf && (m_own == 0), xf && (m_own == 1), ed});
      if (Write_Req_Sig) begin
         logc.push_back(Ack1_Sig ? 1 : 0);
         logd.push_back(FIFO_Write_Data);
         logt.push_back(cyc);
      end
      cyc++;
   endtask

   // Single compare process, away from the active edge.
   always @(negedge CLK) compare_cycle();

   task automatic drive();
      Req0_Sig  = en0 && (q0.size() > 0);
      Data0     = Req0_Sig ? q0[0][7:0] : 8'h00;
      Last0_Sig = Req0_Sig ? q0[0][8] : 1'b0;
      Req1_Sig  = en1 && (q1.size() > 0);
      Data1     = Req1_Sig ? q1[0][7:0] : 8'h00;
      Last1_Sig = Req1_Sig ? q1[0][8] : 1'b0;
   endtask

   // One clock: note acks mid-cycle, pop accepted bytes after the edge.
   task automatic cycle();
      logic a0, a1;
      @(negedge CLK);
      a0 = Ack0_Sig;
      a1 = Ack1_Sig;
      @(posedge CLK);
      #1;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      drive();
   endtask

   task automatic run_until_log(input string name, input int n, input int budget);
      int k = 0;
      while (logd.size() < n && k < budget) begin
         cycle();
         k++;
      end
      chk({"log_count_", name}, logd.size(), n);
   endtask

   task automatic expect_log(input string name, input int idx, input int ch, input logic [7:0] d);
      logic [31:0] act;
      act = (idx < logd.size()) ? {23'd0, logc[idx][0], logd[idx]} : 32'hFFFF_FFFF;
      chk(name, act, {23'd0, ch[0], d});
   endtask

   task automatic expect_gap(input string name, input int i, input int j, input int gap);
      logic [31:0] act;
      act = (j < logt.size()) ? 32'(logt[j] - logt[i]) : 32'hFFFF_FFFF;
      chk(name, act, gap);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      // Reset with both channels already requesting (scenario 2 setup).
      q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b1, 8'hA1});
      q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b1, 8'hB1});
      drive();
      #12;
      chk("reset_outputs", {28'd0, Write_Req_Sig, Ack0_Sig, Ack1_Sig, |FIFO_Write_Data}, 32'd0);
      @(posedge CLK); #1;
      chk("reset_outputs_after_edge", {24'd0, Write_Req_Sig, Ack0_Sig, Ack1_Sig, 5'd0} | FIFO_Write_Data, 32'd0);
      RSTn = 1'b1;

      // Scenario 2: channel 0 first, then channel 1; next pair goes to channel 0.
      run_until_log("s2a", 4, 20);
      expect_log("s2_first0", 0, 0, 8'hA0);
      expect_log("s2_first1", 1, 0, 8'hA1);
      expect_log("s2_then0",  2, 1, 8'hB0);
      expect_log("s2_then1",  3, 1, 8'hB1);
      q0.push_back({1'b0, 8'hC0}); q0.push_back({1'b1, 8'hC1});
      q1.push_back({1'b0, 8'hD0}); q1.push_back({1'b1, 8'hD1});
      drive();
      run_until_log("s2b", 8, 20);
      expect_log("s2_pair2_ch0", 4, 0, 8'hC0);
      expect_log("s2_pair2_ch1", 6, 1, 8'hD0);

      // Scenario 1: three back-to-back bytes on channel 0.
      b = logd.size();
      q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
      drive();
      run_until_log("s1", b + 3, 20);
      expect_log("s1_b0", b,     0, 8'h41);
      expect_log("s1_b1", b + 1, 0, 8'h42);
      expect_log("s1_b2", b + 2, 0, 8'h43);
      expect_gap("s1_consec01", b, b + 1, 1);
      expect_gap("s1_consec12", b + 1, b + 2, 1);
      repeat (2) cycle();

      // Scenario 3: FIFO full for 5 cycles mid-packet on channel 1.
      b = logd.size();
      q1.push_back({1'b0, 8'h51}); q1.push_back({1'b0, 8'h52}); q1.push_back({1'b1, 8'h53});
      drive();
      run_until_log("s3a", b + 1, 20);
      Full_Sig = 1'b1;
      repeat (5) cycle();
      chk("s3_no_write_in_stall", logd.size(), b + 1);
      Full_Sig = 1'b0;
      run_until_log("s3b", b + 3, 20);
      expect_log("s3_b1", b + 1, 1, 8'h52);
      expect_log("s3_b2", b + 2, 1, 8'h53);
      expect_gap("s3_stall_gap", b, b + 1, 6);

      // Scenario 4: 20-byte stream on channel 0 split by the burst limit.
      b = logd.size();
      for (int i = 0; i < 20; i++) q0.push_back({(i == 19), 8'(8'h60 + i)});
      q1.push_back({1'b0, 8'h70}); q1.push_back({1'b1, 8'h71});
      drive();
      run_until_log("s4", b + 22, 80);
      expect_log("s4_burst_end", b + 15, 0, 8'h6F);
      expect_log("s4_ch1_first", b + 16, 1, 8'h70);
      expect_log("s4_ch1_last",  b + 17, 1, 8'h71);
      expect_log("s4_rest_first", b + 18, 0, 8'h70);
      expect_log("s4_rest_last",  b + 21, 0, 8'h73);
      expect_gap("s4_release_gap", b + 15, b + 16, 2);

      // Scenario 5: channel 0 goes quiet without Last; timeout frees the FIFO.
      b = logd.size();
      en1 = 1'b0;
      q1.push_back({1'b1, 8'h81});
      q0.push_back({1'b0, 8'h90}); q0.push_back({1'b0, 8'h91});
      drive();
      run_until_log("s5a", b + 2, 20);
      en1 = 1'b1;
      drive();
      run_until_log("s5b", b + 3, 400);
      expect_log("s5_ch1_after_timeout", b + 2, 1, 8'h81);
      expect_gap("s5_timeout_gap", b + 1, b + 2, TO + 2);

      // Scenario 6: reset mid-packet abandons it; channel 0 wins next.
      repeat (2) cycle();
      b = logd.size();
      for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 8'(8'hA0 + i)});
      drive();
      run_until_log("s6a", b + 2, 20);
      chk("s6_pre_reset_write", {31'd0, Write_Req_Sig}, 32'd1);
      #2 RSTn = 1'b0;
      #1;
      chk("s6_async_reset_outputs", {23'd0, Write_Req_Sig, Ack0_Sig, FIFO_Write_Data}, 32'd0);
      q0.delete(); q1.delete();
      drive();
      repeat (2) cycle();
      RSTn = 1'b1;
      chk("s6_abandoned", logd.size(), b + 2);
      b = logd.size();
      q0.push_back({1'b0, 8'hB0}); q0.push_back({1'b1, 8'hB1});
      q1.push_back({1'b1, 8'hC0});
      drive();
      run_until_log("s6b", b + 3, 20);
      expect_log("s6_ch0_first", b,     0, 8'hB0);
      expect_log("s6_ch1_next",  b + 2, 1, 8'hC0);
      repeat (3) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_tx_arbiter_module
